// File: rtl/apb_gpi_periph.sv
// apb_gpi_periph: APB responder for the general-purpose input port.
// Synchronizes external pins into a read-only IDR; optional edge IRQ.
//
// Ports:
//   PCLK     in   1      clock, all state on rising edge
//   PRESET   in   1      async active-low reset
//   PADDR    in   32     byte address, [11:2] decoded
//   PWRITE   in   1      1 = write
//   PENABLE  in   1      APB access phase
//   PWDATA   in   32     write data
//   PSEL     in   1      slot select
//   PRDATA   out  32     read data, valid while PREADY
//   PREADY   out  1      transfer complete (one wait state)
//   gpi      in   WIDTH  asynchronous input pins
//   irq      out  1      level interrupt, |(ISR & IER)
//
// Build option: define GPI_IRQ_EN to implement the edge detector,
// IER/EDGE/ISR registers and irq. Without it those registers read 0,
// ignore writes, and irq is tied low; IDR and bus timing are unchanged.
//
// Register map: 0x0 IDR (RO), 0x4 IER, 0x8 EDGE (1=rise), 0xC ISR (W1C).
// Any access with PADDR[11:4] != 0 reads 0 and ignores writes.

module apb_gpi_periph #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic [31:0]      PADDR,
   input  logic             PWRITE,
   input  logic             PENABLE,
   input  logic [31:0]      PWDATA,
   input  logic             PSEL,
   output logic [31:0]      PRDATA,
   output logic             PREADY,
   input  logic [WIDTH-1:0] gpi,
   output logic             irq
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RESP = 1'b1;

   localparam logic [1:0] OFS_IDR  = 2'd0;
   localparam logic [1:0] OFS_IER  = 2'd1;
   localparam logic [1:0] OFS_EDGE = 2'd2;
   localparam logic [1:0] OFS_ISR  = 2'd3;

   // ------------------------------------------------------------
   // Input synchronizer
   // ------------------------------------------------------------
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= gpi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------
   // APB decode
   // ------------------------------------------------------------
   logic       state_q;
   logic       state_d;
   logic [31:0] prdata_q;
   logic [31:0] prdata_d;
   logic       access;
   logic       in_range;
   logic       wr_en;
   logic       rd_en;
   logic [1:0] ofs;
   logic [31:0] rdata;

   // The access phase is acted on only from IDLE; the second cycle of
   // PSEL & PENABLE (while PREADY is high) is the same transfer.
   assign access   = (state_q == ST_IDLE) && PSEL && PENABLE;
   assign in_range = (PADDR[11:4] == 8'h00);
   assign ofs      = PADDR[3:2];
   assign wr_en    = access && PWRITE && in_range;
   assign rd_en    = access && !PWRITE;

   // Bits outside the decoded address and above WIDTH are don't-care.
   logic unused_bus;
   assign unused_bus = ^{PADDR[31:12], PADDR[1:0], PWDATA};

`ifdef GPI_IRQ_EN
   // ------------------------------------------------------------
   // Edge detect and interrupt registers
   // ------------------------------------------------------------
   localparam int CW = $clog2(SYNC_STAGES + 2);

   logic [WIDTH-1:0] ier_q;
   logic [WIDTH-1:0] ier_d;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] edge_d;
   logic [WIDTH-1:0] isr_q;
   logic [WIDTH-1:0] isr_d;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] w1c;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             primed_q;
   logic             primed_d;

   // Hold off edge events until the synchronizer and prev register
   // have both filled with real pin values after reset.
   always_comb begin
      cnt_d    = cnt_q;
      primed_d = primed_q;
      if (!primed_q) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(SYNC_STAGES)) begin
            primed_d = 1'b1;
         end
      end
   end

   always_comb begin
      evt = '0;
      if (primed_q) begin
         evt = (edge_q & sync & ~prev_q)
             | (~edge_q & ~sync & prev_q);
      end
   end

   always_comb begin
      ier_d  = ier_q;
      edge_d = edge_q;
      w1c    = '0;
      if (wr_en) begin
         unique case (ofs)
            OFS_IER:  ier_d  = PWDATA[WIDTH-1:0];
            OFS_EDGE: edge_d = PWDATA[WIDTH-1:0];
            OFS_ISR:  w1c    = PWDATA[WIDTH-1:0];
            default:  ;
         endcase
      end
   end

   // A new event on the same edge as its W1C keeps the flag set.
   assign isr_d = (isr_q & ~w1c) | evt;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         ier_q    <= '0;
         edge_q   <= '0;
         isr_q    <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         primed_q <= 1'b0;
      end else begin
         ier_q    <= ier_d;
         edge_q   <= edge_d;
         isr_q    <= isr_d;
         prev_q   <= sync;
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
      end
   end

   assign irq = |(isr_q & ier_q);

   always_comb begin
      rdata = '0;
      if (in_range) begin
         unique case (ofs)
            OFS_IDR:  rdata = 32'(sync);
            OFS_IER:  rdata = 32'(ier_q);
            OFS_EDGE: rdata = 32'(edge_q);
            OFS_ISR:  rdata = 32'(isr_q);
            default:  rdata = '0;
         endcase
      end
   end
`else
   logic unused_wr;
   assign unused_wr = wr_en;

   assign irq = 1'b0;

   always_comb begin
      rdata = '0;
      if (in_range && (ofs == OFS_IDR)) begin
         rdata = 32'(sync);
      end
   end
`endif

   // ------------------------------------------------------------
   // APB FSM: IDLE -> RESP (PREADY) -> IDLE
   // ------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      prdata_d = prdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (access) begin
               state_d = ST_RESP;
            end
            if (rd_en) begin
               prdata_d = rdata;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q  <= ST_IDLE;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         prdata_q <= prdata_d;
      end
   end

   // Decoded straight from state so reset drops it asynchronously.
   assign PREADY = (state_q == ST_RESP);
   assign PRDATA = prdata_q;

endmodule
